alu_issue_ctrl: RTL

Sequencing stage directly upstream of the 4-bit ALU output multiplexer. It accepts one instruction (4-bit opcode plus 4-bit operand) per valid/ready handshake and drives the ALU's `control` select and operands. It writes the selected ALU result back into a 4-bit accumulator, updates zero/carry/error flags, and pulses `done` once per retired instruction. The accumulator feeds the ALU's A operand, so successive instructions chain.

---
 rtl/alu_issue_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Sequencing stage in front of the 4-bit ALU output mux. Accepts one
//   instruction (opcode + operand) per valid/ready handshake, drives the ALU
//   select and operands for one EXEC cycle, writes the ALU result back into
//   the accumulator and flags, then pulses done. One instruction per 3 cycles.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     instruction handshake (accepted only in IDLE)
//   in_opcode, in_operand 4-bit opcode and B operand
//   acc_clr               sync clear of accumulator and flags, any state
//   alu_control           ALU mux select (0 outside EXEC and for illegal ops)
//   alu_a, alu_b          ALU operands (A is the accumulator)
//   alu_result, alu_carry ALU combinational result and carry/borrow
//   acc                   accumulator
//   flag_z/flag_c/flag_err zero, carry, illegal-opcode flags
//   done                  one-cycle retire pulse
module alu_issue_ctrl #(
  parameter logic [3:0] ACC_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_opcode,
  input  logic [3:0] in_operand,
  input  logic       acc_clr,
  output logic [3:0] alu_control,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  output logic [3:0] acc,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_err,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state;
  logic   lat_legal;   // latched opcode was legal
  logic   lat_addsub;  // latched opcode produces a meaningful carry

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010, 4'b1011,
      4'b1100, 4'b1101, 4'b1110, 4'b1111: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  assign alu_a = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      done        <= 1'b0;
      alu_control <= 4'b0000;
      alu_b       <= 4'b0000;
      lat_legal   <= 1'b0;
      lat_addsub  <= 1'b0;
      acc         <= ACC_RESET;
      flag_z      <= (ACC_RESET == 4'b0000);
      flag_c      <= 1'b0;
      flag_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            lat_legal   <= is_legal(in_opcode);
            lat_addsub  <= (in_opcode[3:1] == 3'b010);
            // Illegal opcodes select mux input 0 so the ALU stays quiet.
            alu_control <= is_legal(in_opcode) ? in_opcode : 4'b0000;
            alu_b       <= in_operand;
            in_ready    <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          alu_control <= 4'b0000;
          done        <= 1'b1;
          state       <= DONE;
          if (lat_legal) begin
            acc      <= alu_result;
            flag_z   <= (alu_result == 4'b0000);
            flag_c   <= lat_addsub ? alu_carry : 1'b0;
            flag_err <= 1'b0;
          end else begin
            flag_err <= 1'b1;
          end
        end
        DONE: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          done        <= 1'b0;
          in_ready    <= 1'b1;
          alu_control <= 4'b0000;
          state       <= IDLE;
        end
      endcase
      // Placed last so a clear during EXEC overrides the writeback above.
      if (acc_clr) begin
        acc      <= ACC_RESET;
        flag_z   <= (ACC_RESET == 4'b0000);
        flag_c   <= 1'b0;
        flag_err <= 1'b0;
      end
    end
  end

endmodule
